// File: rtl/tri_bus_pkg.sv
// Shared definitions for the tri-state bus arbiter.
//   state_t   : arbiter FSM state encoding (IDLE / OWN / TURN)
//   HOLD_W    : width of the hold counter (covers MAX_HOLD up to 255)
//   TURN_W    : width of the turnaround counter (covers TURNAROUND up to 7)
//   idx_width : width of a requester index for a given requester count
package tri_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  localparam int HOLD_W = 8;
  localparam int TURN_W = 3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    : request vector
//   last   : index of the previous owner; search starts at last+1 and wraps
//   onehot : one-hot winner (zero when no request)
//   idx    : winner index (zero when no request)
//   any    : at least one request present
module rr_pick
  import tri_bus_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    // Offset N_REQ wraps back to the last owner itself, so it gets lowest priority.
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last) + i) % N_REQ;
      if (!any && req[cand[IW-1:0]]) begin
        any                 = 1'b1;
        onehot[cand[IW-1:0]] = 1'b1;
        idx                 = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter / sequencer for a shared tri-state bus.
// Grants one owner at a time, drives the per-requester tri_buf enables and
// inserts an all-off turnaround gap between owners.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   req      : level request per requester
//   gnt      : one-hot (or zero) grant, registered
//   drv_en   : tri_buf enables, identical to gnt
//   owner    : index of current owner, meaningful only while bus_busy
//   bus_busy : a grant is active
//
// state | meaning
// IDLE  | bus free, arbitrate among pending requests
// OWN   | one requester owns the bus, hold counter running
// TURN  | all enables off, turnaround counter draining
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             drv_en,
  output logic [idx_width(N_REQ)-1:0]  owner,
  output logic                         bus_busy
);

  localparam int IW = idx_width(N_REQ);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND);
  localparam logic [IW-1:0]     LAST_INIT = IW'(N_REQ - 1);

  state_t            state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [TURN_W-1:0] turn_cnt, turn_n;
  logic [IW-1:0]     last_owner, last_n;
  logic [N_REQ-1:0]  gnt_n;
  logic [IW-1:0]     owner_n;
  logic              busy_n;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              owner_req;
  logic              others_req;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req    (req),
    .last   (last_owner),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign owner_req  = req[owner];
  assign others_req = |(req & ~gnt);

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    turn_n  = turn_cnt;
    last_n  = last_owner;
    gnt_n   = gnt;
    owner_n = owner;
    busy_n  = bus_busy;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_n = ST_OWN;
          gnt_n   = pick_onehot;
          owner_n = pick_idx;
          busy_n  = 1'b1;
          hold_n  = '0;
        end
      end
      ST_OWN: begin
        if (hold_cnt < HOLD_MAX) hold_n = hold_cnt + 1'b1;
        // The >= also covers a contender arriving after the counter has
        // saturated: it preempts at once instead of waiting forever.
        if (!owner_req || (hold_cnt >= HOLD_MAX - 1'b1 && others_req)) begin
          state_n = ST_TURN;
          gnt_n   = '0;
          busy_n  = 1'b0;
          last_n  = owner;
          turn_n  = TURN_LOAD;
        end
      end
      ST_TURN: begin
        if (turn_cnt != '0) turn_n = turn_cnt - 1'b1;
        if (turn_cnt <= TURN_W'(1)) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      turn_cnt   <= '0;
      last_owner <= LAST_INIT;
      gnt        <= '0;
      owner      <= '0;
      bus_busy   <= 1'b0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_n;
      turn_cnt   <= turn_n;
      last_owner <= last_n;
      gnt        <= gnt_n;
      owner      <= owner_n;
      bus_busy   <= busy_n;
    end
  end

  assign drv_en = gnt;

endmodule
